fm_modulate: RTL and testbench

//  FM modulator; transmit-side counterpart of the demodulate stage. It takes signed audio samples on an
//  AXI-Stream slave and holds each one for UPSAMPLE output beats. On every beat it advances a 16-bit

---
 rtl/fm_modulate_if.sv | 24 ++
 rtl/fm_modulate.sv | 117 +++++++++++
 tb/tb_fm_modulate.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fm_modulate_if.sv
// Signal bundle for the fm_modulate sample input and angle-word output streams.
// master: source/sink side that faces the modulator; slave: the modulator's own view.
interface fm_modulate_if;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;

    modport master (
        output s_tvalid, s_tdata, s_tstrb, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tstrb, m_tlast
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tstrb, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tstrb, m_tlast
    );
endinterface

// File: rtl/fm_modulate.sv
// FM modulator: holds each audio sample for UPSAMPLE beats, advancing a 16-bit phase
// accumulator by carrier + scaled sample per beat and emitting {angle, magnitude}.
module fm_modulate #(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned UPSAMPLE               = 4,
    parameter logic [15:0] CARRIER_INC            = 16'h0000,
    parameter logic [15:0] MAGNITUDE              = 16'h7FFF
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    input  logic [3:0]                            sw,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                  m00_axis_tlast
);

    localparam int unsigned CW = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(UPSAMPLE - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t r_state, w_state_next;

    logic [CW-1:0]                           r_beat_cnt;
    logic [15:0]                             r_sample;
    logic                                    r_held_tlast;
    logic [15:0]                             r_phase;
    logic                                    r_m_tvalid;
    logic                                    r_m_tlast;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]       r_m_tdata;
    logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0]   r_m_tstrb;

    logic        w_last_beat;
    logic        w_issue;
    logic        w_s_tready;
    logic        w_accept;
    logic [15:0] w_scaled;
    logic [15:0] w_inc;
    logic        w_unused_bits;

    assign w_unused_bits = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16]};

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) r_state <= IDLE;
        else                   r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = EMIT;
            EMIT: if (w_issue && w_last_beat && !w_accept) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Ready is gated by reset so nothing is accepted while aresetn is held low.
    always_comb begin
        w_last_beat = (r_beat_cnt == LAST_BEAT);
        w_issue     = (r_state == EMIT) && (!r_m_tvalid || m00_axis_tready);
        w_s_tready  = s00_axis_aresetn && ((r_state == IDLE) || (w_issue && w_last_beat));
        w_accept    = s00_axis_tvalid && w_s_tready;
    end

    always_comb begin
        w_scaled = 16'($signed(r_sample) >>> sw);
        w_inc    = (sw == 4'hF) ? 16'h0100 : (CARRIER_INC + w_scaled);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_beat_cnt   <= '0;
            r_sample     <= '0;
            r_held_tlast <= 1'b0;
            r_phase      <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tstrb    <= '0;
        end else begin
            if (w_issue) begin
                r_m_tdata  <= C_M00_AXIS_TDATA_WIDTH'({r_phase, MAGNITUDE});
                r_m_tvalid <= 1'b1;
                r_m_tstrb  <= '1;
                r_m_tlast  <= r_held_tlast && w_last_beat;
                r_phase    <= r_phase + w_inc;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end else if (r_m_tvalid && m00_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
            // Accepting on the final beat overrides the beat increment above.
            if (w_accept) begin
                r_sample     <= s00_axis_tdata[15:0];
                r_held_tlast <= s00_axis_tlast;
                r_beat_cnt   <= '0;
            end
        end
    end

    assign s00_axis_tready = w_s_tready;
    assign m00_axis_tvalid = r_m_tvalid;
    assign m00_axis_tdata  = r_m_tdata;
    assign m00_axis_tstrb  = r_m_tstrb;
    assign m00_axis_tlast  = r_m_tlast;

endmodule

// File: tb/tb_fm_modulate.sv
// Scoreboard bench for fm_modulate: a driver pushes expected beats from a phase model,
// a monitor pops and compares each consumed output beat.
module tb_fm_modulate;

    localparam int          UPS     = 4;
    localparam logic [15:0] CARRIER = 16'h0040;
    localparam logic [15:0] MAG     = 16'h7FFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       stall_en = 1'b0;
    logic       gap_watch = 1'b0;
    int         gap_cnt = 0;
    int         phase_beats = 0;
    int         beats_popped = 0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] exp_q[$];
    int          model_phase = 0;

    fm_modulate_if bus();

    fm_modulate #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .UPSAMPLE(UPS),
        .CARRIER_INC(CARRIER),
        .MAGNITUDE(MAG)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid (bus.s_tvalid),
        .s00_axis_tready (bus.s_tready),
        .s00_axis_tdata  (bus.s_tdata),
        .s00_axis_tstrb  (bus.s_tstrb),
        .s00_axis_tlast  (bus.s_tlast),
        .sw              (sw),
        .m00_axis_tready (bus.m_tready),
        .m00_axis_tvalid (bus.m_tvalid),
        .m00_axis_tdata  (bus.m_tdata),
        .m00_axis_tstrb  (bus.m_tstrb),
        .m00_axis_tlast  (bus.m_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: each sample yields UPS beats; angle is the running phase before each step.
    function automatic void model_sample(input logic [15:0] s, input logic last);
        int sv;
        int inc;
        sv = $signed(s);
        if (sw == 4'hF) inc = 256;
        else            inc = int'(CARRIER) + (sv >>> sw);
        for (int b = 0; b < UPS; b++) begin
            exp_q.push_back({last && (b == UPS - 1), model_phase[15:0], MAG});
            model_phase = (model_phase + inc) & 32'h0000FFFF;
        end
    endfunction

    task automatic send(input logic [15:0] s, input logic last);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = {$urandom_range(0, 65535), s} & 32'hFFFFFFFF;
        bus.s_tstrb  = 4'($urandom_range(0, 15));
        bus.s_tlast  = last;
        #1;
        while (!bus.s_tready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.s_tready) begin
            check("s_tready_timeout", 64'd0, 64'd1);
        end else begin
            model_sample(s, last);
            @(posedge clk);
        end
        #1 bus.s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial forever begin
        @(negedge clk);
        bus.m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic        stalled = 1'b0;
    logic [32:0] held_beat;

    initial forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (bus.m_tvalid && stalled)
                check("stall_hold", 64'({bus.m_tlast, bus.m_tdata}), 64'(held_beat));
            if (gap_watch && phase_beats > 0 && exp_q.size() > 0 && !bus.m_tvalid)
                gap_cnt++;
            if (bus.m_tvalid && bus.m_tready) begin
                stalled = 1'b0;
                phase_beats++;
                beats_popped++;
                check("tstrb", 64'(bus.m_tstrb), 64'hF);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'({bus.m_tlast, bus.m_tdata}), 64'h1_FFFF_FFFF_F);
                end else begin
                    check("beat", 64'({bus.m_tlast, bus.m_tdata}), 64'(exp_q.pop_front()));
                end
            end else if (bus.m_tvalid) begin
                stalled   = 1'b1;
                held_beat = {bus.m_tlast, bus.m_tdata};
            end
        end
    end

    initial begin
        int base;
        int waited;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tstrb  = '0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("rst_tdata",  64'(bus.m_tdata),  64'd0);
        check("rst_tstrb",  64'(bus.m_tstrb),  64'd0);
        check("rst_tlast",  64'(bus.m_tlast),  64'd0);
        check("rst_s_tready", 64'(bus.s_tready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous-throughput run: constant sample, no backpressure.
        sw = 4'd0;
        gap_watch = 1'b1;
        phase_beats = 0;
        for (int i = 0; i < 20; i++) send(16'h1000, 1'($urandom_range(0, 1)));
        drain();
        gap_watch = 1'b0;
        check("no_gaps", 64'(gap_cnt), 64'd0);

        // Random samples, random deviation shift, random backpressure.
        stall_en = 1'b1;
        for (int blk = 0; blk < 4; blk++) begin
            sw = 4'($urandom_range(0, 14));
            for (int i = 0; i < 25; i++)
                send(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            drain();
        end

        // Test ramp mode and a small positive sample with tlast.
        sw = 4'hF;
        for (int i = 0; i < 10; i++) send(16'($urandom_range(0, 65535)), 1'b0);
        drain();
        sw = 4'd2;
        send(16'h0400, 1'b1);
        drain();
        sw = 4'd1;
        send(16'h8000, 1'b1);
        drain();

        // Reset partway through a sample's beats.
        stall_en = 1'b0;
        sw = 4'd0;
        base = beats_popped;
        send(16'h2345, 1'b1);
        waited = 0;
        while (beats_popped < base + 2 && waited < 100) begin
            @(negedge clk);
            #3;
            waited++;
        end
        check("pre_reset_beats", 64'(beats_popped - base), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("midrst_s_tready", 64'(bus.s_tready), 64'd0);
        check("midrst_tdata", 64'(bus.m_tdata), 64'd0);
        exp_q.delete();
        model_phase = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        stall_en = 1'b1;
        for (int i = 0; i < 5; i++)
            send(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        drain();

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
